fifo_rd_arbiter: RTL and testbench

Read-side arbiter that shares the single read port of the async FIFO among NREQ consumers in the read clock domain. It grants the port round-robin, in fixed-length bursts, and pops words through the FIFO's show-ahead read interface (rd_rq/empty). Each word is delivered through a one-deep registered output stage tagged with the owner's ID and a last-beat marker.

---
 rtl/fifo_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: shares the async FIFO's show-ahead read port among NREQ
// read-domain consumers. Round-robin grant, fixed BURST words per grant,
// one-deep registered output stage tagged with owner id and last-beat flag.
//
// Ports:
//   r_clk, rst_n       read clock, async active-low reset
//   req_i[NREQ]        per-consumer level request
//   rdy_i[NREQ]        per-consumer ready (only the owner's bit matters)
//   fifo_empty_i       FIFO empty flag
//   fifo_rdata_i       FIFO head word (valid when not empty)
//   rd_rq_o            FIFO pop request (combinational)
//   gnt_o[NREQ]        registered one-hot grant
//   out_valid_o, out_data_o, out_id_o, out_last_o  registered output stage
module fifo_rd_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic                     r_clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          rdy_i,
  input  logic                     fifo_empty_i,
  input  logic [WIDTH-1:0]         fifo_rdata_i,
  output logic                     rd_rq_o,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [$clog2(NREQ)-1:0]  out_id_o,
  output logic                     out_last_o
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(BURST) + 1;

  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   rr_q, rr_d;        // last granted index, doubles as current owner
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             last_q, last_d;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;
  logic             pop;
  logic             owner_rdy;
  logic             last_beat;

  // Round-robin search starting just after the last owner, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    cand  = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = IDW'((int'(rr_q) + i) % int'(NREQ));
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign owner_rdy = rdy_i[rr_q];
  assign last_beat = (cnt_q == CW'(BURST - 1));
  assign pop       = (state_q == XFER) && !fifo_empty_i && (!valid_q || owner_rdy);
  assign rd_rq_o   = pop;

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          rr_d        = pick;
          cnt_d       = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (pop) begin
          data_d  = fifo_rdata_i;
          valid_d = 1'b1;
          id_d    = rr_q;
          last_d  = last_beat;
          cnt_d   = CW'(cnt_q + CW'(1));
          if (last_beat) state_d = HOLD;
        end else if (valid_q && owner_rdy) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (owner_rdy) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset leaves rr on NREQ-1 so index 0 wins first.
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= IDW'(NREQ - 1);
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_id_o    = id_q;
  assign out_last_o  = last_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a FIFO model and an output scoreboard.
module tb_fifo_rd_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic             r_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req_i = '0;
  logic [NREQ-1:0]  rdy_i = '1;
  logic             fifo_empty_i = 1'b1;
  logic [WIDTH-1:0] fifo_rdata_i = '0;
  logic             rd_rq_o;
  logic [NREQ-1:0]  gnt_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic [1:0]       out_id_o;
  logic             out_last_o;

  fifo_rd_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .r_clk(r_clk), .rst_n(rst_n), .req_i(req_i), .rdy_i(rdy_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i), .rd_rq_o(rd_rq_o),
    .gnt_o(gnt_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_id_o(out_id_o), .out_last_o(out_last_o)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [1:0]       id;
    logic             last;
  } ent_t;

  logic [WIDTH-1:0] fifo_mem[$];
  ent_t             sb[$];
  int               exp_owners[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               mbeat = 0;
  int               cur_owner = 0;
  int               run = 0;
  int               max_run = 0;
  int               acc_cnt = 0;
  logic             stalled = 1'b0;
  logic [WIDTH-1:0] st_d;
  logic [1:0]       st_id;
  logic             st_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model, pop tracking and scoreboard; runs just after each falling edge.
  always begin
    @(negedge r_clk);
    #1;
    if (rst_n) begin
      fifo_empty_i = (fifo_mem.size() == 0);
      if (fifo_mem.size() != 0) fifo_rdata_i = fifo_mem[0];
    end
    #1;
    if (rst_n) begin
      if (stalled) begin
        check("hold_data", 32'(out_data_o), 32'(st_d));
        check("hold_id", 32'(out_id_o), 32'(st_id));
        check("hold_last", 32'(out_last_o), 32'(st_last));
      end
      stalled = 1'b0;
      if (out_valid_o && !rdy_i[out_id_o]) begin
        check("rdrq_bp", 32'(rd_rq_o), 32'd0);
        stalled = 1'b1;
        st_d = out_data_o; st_id = out_id_o; st_last = out_last_o;
      end
      if (out_valid_o && rdy_i[out_id_o]) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          ent_t e;
          e = sb.pop_front();
          check("out_data", 32'(out_data_o), 32'(e.d));
          check("out_id", 32'(out_id_o), 32'(e.id));
          check("out_last", 32'(out_last_o), 32'(e.last));
          acc_cnt++;
        end
      end
      if (rd_rq_o) begin
        ent_t n;
        run++;
        if (run > max_run) max_run = run;
        if (fifo_mem.size() == 0) begin
          check("pop_empty", 32'd1, 32'd0);
        end else begin
          if (mbeat == 0) begin
            if (exp_owners.size() == 0) begin
              check("unexpected_grant", 32'(gnt_o), 32'd0);
              cur_owner = 0;
            end else begin
              cur_owner = exp_owners.pop_front();
            end
          end
          check("pop_gnt", 32'(gnt_o), 32'(1 << cur_owner));
          n.d    = fifo_mem.pop_front();
          n.id   = 2'(cur_owner);
          n.last = (mbeat == BURST - 1);
          sb.push_back(n);
          mbeat = (mbeat + 1) % BURST;
        end
      end else begin
        run = 0;
      end
    end
  end

  task automatic flush();
    fifo_mem.delete(); sb.delete(); exp_owners.delete();
    mbeat = 0; run = 0; max_run = 0; acc_cnt = 0; stalled = 1'b0;
    fifo_empty_i = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    rst_n = 1'b0;
    req_i = '0;
    rdy_i = '1;
    flush();
    repeat (2) @(negedge r_clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input logic [NREQ-1:0] v);
    @(negedge r_clk);
    req_i = v;
  endtask

  task automatic set_rdy(input logic [NREQ-1:0] v);
    @(negedge r_clk);
    rdy_i = v;
  endtask

  task automatic wait_gnt(input int budget);
    int k = 0;
    do begin
      @(negedge r_clk); #3; k++;
    end while (gnt_o == '0 && k < budget);
    if (gnt_o == '0) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    do begin
      @(negedge r_clk); #3; k++;
    end while (!out_valid_o && k < budget);
    if (!out_valid_o) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    logic done;
    do begin
      @(negedge r_clk); #3; k++;
      done = (sb.size() == 0) && (exp_owners.size() == 0) && (fifo_mem.size() == 0) &&
             (mbeat == 0) && !out_valid_o;
    end while (!done && k < budget);
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state.
    #3;
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_data", 32'(out_data_o), 32'd0);
    check("rst_id", 32'(out_id_o), 32'd0);
    check("rst_last", 32'(out_last_o), 32'd0);
    check("rst_rdrq", 32'(rd_rq_o), 32'd0);
    do_reset();

    // Single consumer, preloaded FIFO.
    for (int i = 0; i < 4; i++) fifo_mem.push_back(8'(8'h10 + i));
    exp_owners.push_back(0);
    set_req(4'b0001);
    wait_gnt(10);
    check("single_gnt", 32'(gnt_o), 32'b0001);
    set_req(4'b0000);
    drain(40);
    check("single_run", 32'(max_run), 32'd4);
    check("single_gnt_end", 32'(gnt_o), 32'd0);
    check("single_acc", 32'(acc_cnt), 32'd4);

    // Round-robin fairness across four requesters.
    do_reset();
    for (int i = 0; i < 16; i++) fifo_mem.push_back(8'(8'h20 + i));
    for (int i = 0; i < 4; i++) exp_owners.push_back(i);
    set_req(4'b1111);
    drain(200);
    check("rr_acc", 32'(acc_cnt), 32'd16);
    @(negedge r_clk); #3;
    check("rr_wrap_gnt", 32'(gnt_o), 32'b0001);

    // Output backpressure mid-burst.
    do_reset();
    for (int i = 0; i < 4; i++) fifo_mem.push_back(8'(8'h40 + i));
    exp_owners.push_back(0);
    set_req(4'b0001);
    wait_valid(10);
    set_req(4'b0000);
    set_rdy(4'b1110);
    repeat (2) @(negedge r_clk);
    #3;
    check("bp_rdrq", 32'(rd_rq_o), 32'd0);
    check("bp_valid", 32'(out_valid_o), 32'd1);
    set_rdy(4'b1111);
    drain(40);
    check("bp_acc", 32'(acc_cnt), 32'd4);

    // FIFO runs empty mid-burst.
    do_reset();
    fifo_mem.push_back(8'h50); fifo_mem.push_back(8'h51);
    exp_owners.push_back(0);
    set_req(4'b0001);
    set_req(4'b0000);
    repeat (5) @(negedge r_clk);
    #3;
    check("empty_rdrq", 32'(rd_rq_o), 32'd0);
    check("empty_gnt", 32'(gnt_o), 32'b0001);
    check("empty_valid", 32'(out_valid_o), 32'd0);
    check("empty_acc", 32'(acc_cnt), 32'd2);
    fifo_mem.push_back(8'h52); fifo_mem.push_back(8'h53);
    drain(40);
    check("empty_acc_end", 32'(acc_cnt), 32'd4);

    // Request drop is ignored mid-burst; next grant goes round to 0.
    do_reset();
    for (int i = 0; i < 8; i++) fifo_mem.push_back(8'(8'h60 + i));
    exp_owners.push_back(2);
    exp_owners.push_back(0);
    set_req(4'b0100);
    wait_valid(10);
    set_req(4'b0001);
    drain(80);
    check("drop_acc", 32'(acc_cnt), 32'd8);

    // Asynchronous reset mid-burst.
    do_reset();
    for (int i = 0; i < 4; i++) fifo_mem.push_back(8'(8'h70 + i));
    exp_owners.push_back(3);
    set_req(4'b1000);
    begin
      int k = 0;
      while (acc_cnt < 2 && k < 20) begin
        @(negedge r_clk); #3; k++;
      end
      if (acc_cnt < 2) check("mid_timeout", 32'd0, 32'd1);
    end
    @(negedge r_clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt_o), 32'd0);
    check("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_rdrq", 32'(rd_rq_o), 32'd0);
    flush();
    req_i = 4'b0110;
    @(negedge r_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) fifo_mem.push_back(8'(8'h80 + i));
    exp_owners.push_back(1);
    wait_gnt(10);
    check("post_rst_gnt", 32'(gnt_o), 32'b0010);
    set_req(4'b0000);
    drain(40);
    check("post_rst_acc", 32'(acc_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
